// File: rtl/stack_seq_pkg.sv
// Shared definitions for the stack sequencer: opcode encodings, FSM state
// encoding, error codes and a small opcode classification helper.
package stack_seq_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_PUSH = 3'b001,
    OP_POP  = 3'b010,
    OP_ADD  = 3'b011,
    OP_SUB  = 3'b100,
    OP_AND  = 3'b101,
    OP_OR   = 3'b110,
    OP_DUP  = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POP1  = 3'd1,
    ST_POP2  = 3'd2,
    ST_CAP   = 3'd3,
    ST_PUSH  = 3'd4,
    ST_PUSH2 = 3'd5
  } state_e;

  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_UNDERFLOW = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW  = 2'b10;

  // Two-operand ALU instructions: consume two entries, push one back.
  function automatic logic is_binary(op_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

endpackage

// File: rtl/stack_seq_alu.sv
// Combinational ALU for the stack sequencer.
// Ports: op (opcode), a (element beneath the former top), b (former top),
//        y (result, modulo 2^WIDTH_DATA). Non-ALU opcodes yield 0.
module stack_seq_alu
  import stack_seq_pkg::*;
#(
  parameter int WIDTH_DATA = 16
) (
  input  op_e                   op,
  input  logic [WIDTH_DATA-1:0] a,
  input  logic [WIDTH_DATA-1:0] b,
  output logic [WIDTH_DATA-1:0] y
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    y = '0;
    unique case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/stack_sequencer.sv
// Stack-machine instruction sequencer driving an external registered stack.
// Ports: clk, reset (async active-high, shared with the stack);
//        instr_valid/instr_op/instr_imm/instr_ready - instruction handshake;
//        stk_push/stk_pop/stk_data_in/stk_data_out - stack strobes and data
//        (stk_data_out valid the cycle after stk_pop);
//        result/result_valid - POP value or ALU result with one-cycle qualifier;
//        err/err_code - one-cycle rejection pulse and reason;
//        depth - tracked stack occupancy.
module stack_sequencer
  import stack_seq_pkg::*;
#(
  parameter int WIDTH_DATA  = 16,
  parameter int STACK_DEPTH = 10
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             instr_valid,
  input  logic [2:0]                       instr_op,
  input  logic [WIDTH_DATA-1:0]            instr_imm,
  output logic                             instr_ready,
  output logic                             stk_push,
  output logic                             stk_pop,
  output logic [WIDTH_DATA-1:0]            stk_data_in,
  input  logic [WIDTH_DATA-1:0]            stk_data_out,
  output logic [WIDTH_DATA-1:0]            result,
  output logic                             result_valid,
  output logic                             err,
  output logic [1:0]                       err_code,
  output logic [$clog2(STACK_DEPTH+1)-1:0] depth
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(STACK_DEPTH);

  state_e                state, state_next;
  op_e                   op_q;
  op_e                   op_in;
  logic [WIDTH_DATA-1:0] data_q;   // immediate, duplicated word or ALU result to push
  logic [WIDTH_DATA-1:0] b_q;      // former top of stack for binary ops
  logic [WIDTH_DATA-1:0] alu_y;
  logic                  live_q;   // holds instr_ready low until the first edge after reset
  logic                  accept;
  logic                  underflow;
  logic                  overflow;

  assign op_in       = op_e'(instr_op);
  assign instr_ready = live_q && (state == ST_IDLE);
  assign accept      = instr_valid && instr_ready;

  assign underflow = accept &&
                     ((((op_in == OP_POP) || (op_in == OP_DUP)) && (depth == '0)) ||
                      (is_binary(op_in) && (depth < DW'(2))));
  assign overflow  = accept && !underflow &&
                     ((op_in == OP_PUSH) || (op_in == OP_DUP)) && (depth == DEPTH_MAX);

  // A is the element that arrives in CAP, B the former top captured in POP2.
  stack_seq_alu #(.WIDTH_DATA(WIDTH_DATA)) u_alu (
    .op (op_q),
    .a  (stk_data_out),
    .b  (b_q),
    .y  (alu_y)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    stk_data_in = '0;
    unique case (state)
      ST_IDLE: begin
        if (accept && !underflow && !overflow) begin
          if (op_in == OP_PUSH)      state_next = ST_PUSH;
          else if (op_in != OP_NOP)  state_next = ST_POP1;
        end
      end
      ST_POP1: begin
        stk_pop    = 1'b1;
        state_next = is_binary(op_q) ? ST_POP2 : ST_CAP;
      end
      ST_POP2: begin
        stk_pop    = 1'b1;
        state_next = ST_CAP;
      end
      ST_CAP: begin
        state_next = (op_q == OP_POP) ? ST_IDLE : ST_PUSH;
      end
      ST_PUSH: begin
        stk_push    = 1'b1;
        stk_data_in = data_q;
        state_next  = (op_q == OP_DUP) ? ST_PUSH2 : ST_IDLE;
      end
      ST_PUSH2: begin
        stk_push    = 1'b1;
        stk_data_in = data_q;
        state_next  = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: every register here is cleared by reset so outputs drop to zero
    // immediately and a partial instruction leaves nothing behind.
    if (reset) begin
      live_q       <= 1'b0;
      op_q         <= OP_NOP;
      data_q       <= '0;
      b_q          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
      err_code     <= ERR_NONE;
      depth        <= '0;
    end else begin
      live_q       <= 1'b1;
      result_valid <= 1'b0;
      err          <= 1'b0;
      err_code     <= ERR_NONE;

      if (stk_push)     depth <= depth + 1'b1;
      else if (stk_pop) depth <= depth - 1'b1;

      if (accept) begin
        op_q   <= op_in;
        data_q <= instr_imm;
        if (underflow) begin
          err      <= 1'b1;
          err_code <= ERR_UNDERFLOW;
        end else if (overflow) begin
          err      <= 1'b1;
          err_code <= ERR_OVERFLOW;
        end
      end

      unique case (state)
        ST_POP2: b_q <= stk_data_out;
        ST_CAP: begin
          if (op_q == OP_POP) begin
            result       <= stk_data_out;
            result_valid <= 1'b1;
          end else if (op_q == OP_DUP) begin
            data_q <= stk_data_out;
          end else begin
            data_q <= alu_y;
          end
        end
        ST_PUSH: begin
          if (is_binary(op_q)) begin
            result       <= data_q;
            result_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/stack_sequencer.md
STACK_SEQUENCER -- requirements
Module: stack_sequencer

Interface
REQ-001 Parameter WIDTH_DATA, default 16: data word width.
REQ-002 Parameter STACK_DEPTH, default 10: maximum entry count tracked for the attached stack.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 instr_valid  in  1  instruction offered.
REQ-006 instr_op  in  3  opcode: 000 NOP, 001 PUSH, 010 POP, 011 ADD, 100 SUB, 101 AND, 110 OR, 111 DUP.
REQ-007 instr_imm  in  WIDTH_DATA  immediate for PUSH.
REQ-008 instr_ready  out  1  sequencer can accept an instruction.
REQ-009 stk_push  out  1  push strobe to the stack.
REQ-010 stk_pop  out  1  pop strobe to the stack.
REQ-011 stk_data_in  out  WIDTH_DATA  word to push.
REQ-012 stk_data_out  in  WIDTH_DATA  popped word from the stack, registered, valid the cycle after stk_pop.
REQ-013 result  out  WIDTH_DATA  last POP value or ALU result.
REQ-014 result_valid  out  1  one-cycle pulse qualifying result.
REQ-015 err  out  1  one-cycle pulse: instruction rejected.
REQ-016 err_code  out  2  01 underflow, 10 overflow, 00 otherwise.
REQ-017 depth  out  $clog2(STACK_DEPTH+1)  current occupancy.

Function
REQ-018 Handshake: an instruction is accepted on an edge with instr_valid && instr_ready; instr_op and instr_imm are stable while valid and not ready.
REQ-019 instr_ready is 1 only in IDLE; stk_push and stk_pop are never both 1; at most one strobe per cycle.
REQ-020 States: IDLE, POP1, POP2, CAP, PUSH, PUSH2.
REQ-021 NOP: accepted in IDLE; stays IDLE; no strobe, no result_valid.
REQ-022 PUSH: IDLE->PUSH (stk_push=1, stk_data_in=imm)->IDLE; 2 cycles per instruction.
REQ-023 POP: IDLE->POP1 (stk_pop)->CAP (capture stk_data_out)->IDLE; result_valid=1 in the first IDLE cycle, result=popped word.
REQ-024 ADD/SUB/AND/OR: IDLE->POP1 (stk_pop)->POP2 (stk_pop, capture B=stk_data_out)->CAP (capture A=stk_data_out)->PUSH (push f(A,B))->IDLE; result_valid in the first IDLE cycle.
REQ-025 Operand order: B is the former top, A is the element beneath it; SUB = A - B.
REQ-026 Arithmetic is modulo 2^WIDTH_DATA; carry and borrow are discarded.
REQ-027 DUP: IDLE->POP1->CAP->PUSH->PUSH2->IDLE; pushes the captured word twice; no result_valid.
REQ-028 depth increments on each stk_push cycle and decrements on each stk_pop cycle.
REQ-029 Underflow: POP/DUP with depth<1, or binary op with depth<2 -> accepted, no strobes, err=1 and err_code=01 in the next cycle, stays IDLE.
REQ-030 Overflow: PUSH or DUP with depth==STACK_DEPTH -> accepted, no strobes, err=1 and err_code=10 in the next cycle.
REQ-031 A binary op at depth==STACK_DEPTH is legal (net -1).

Reset
REQ-032 Reset forces IDLE, depth=0, and all outputs 0 immediately, including mid-sequence; the partial instruction is discarded.
REQ-033 Reset is shared with the attached stack, so depth and stack occupancy realign.
REQ-034 After deassertion, instr_ready=1 on the first clock edge.

Structure
REQ-035 Package stack_seq_pkg holds opcode encodings, state encoding, and err_code values.
REQ-036 Sub-module stack_seq_alu is combinational (A, B, op -> y); all registers live in stack_sequencer.

Verification
REQ-037 Reset, PUSH 7, PUSH 3, SUB -> result=4, result_valid pulse, depth=1.
REQ-038 PUSH 3, PUSH 7, SUB -> result=0xFFFC; PUSH 0xFFFF, PUSH 1, ADD -> result=0x0000.
REQ-039 Empty stack, POP -> err=1, err_code=01, no stk_pop; then PUSH 5, ADD -> err_code=01, depth stays 1.
REQ-040 10 PUSHes then PUSH -> err_code=10, depth=10; DUP -> err_code=10; ADD -> legal, depth=9.
REQ-041 PUSH 9, DUP, POP, POP -> results 9, 9; depth=0; strobe count: pushes=3, pops=3.
REQ-042 Reset asserted in POP2 of ADD -> all outputs 0 immediately, depth=0, instr_ready=1 after release.
